// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS32 core register-file slice.
//   - default widths for the general register file
//   - architectural register indices used by the register file
package mips_cpu_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_RD_DEF     = 2;

    // $zero is hard-wired; $v0 holds function results and is exposed for observation.
    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;

endpackage

// File: rtl/mips_cpu_scoreboard.sv
// Per-register busy scoreboard for multi-cycle producers (loads, mult/div).
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rsv_valid/rsv_addr  request to reserve a register for a pending write
//   clr_valid/clr_addr  a write is landing; its register is no longer pending
//   flush               drop every reservation
//   busy                one busy bit per register (bit 0 is always 0)
//   rsv_ready           rsv_addr can be reserved this cycle
//   rsv_err             sticky: a reservation was attempted on a busy register
module mips_cpu_scoreboard
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic                  clr_valid,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  flush,
    output logic [DEPTH-1:0]      busy,
    output logic                  rsv_ready,
    output logic                  rsv_err
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DEPTH-1:0] busy_next;

    // $zero is always reservable (as a no-op); nothing is reservable during reset.
    assign rsv_ready = !reset && ((rsv_addr == ZERO_ADDR) || !busy[rsv_addr]);

    // Ordering encodes priority: a new reservation overrides a landing write to
    // the same register (a new producer is in flight), and flush overrides everything.
    // NOTE: the default copy on the first line keeps this block free of inferred latches.
    always_comb begin
        busy_next = busy;
        if (clr_valid) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[ZERO_ADDR] = 1'b0;
        if (flush) begin
            busy_next = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (rsv_valid && !rsv_ready) begin
                rsv_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_sb.sv
// MIPS32 general register file with write-to-read bypass and busy scoreboard.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   write/wr_addr/wr_data  register write (writes to $zero are dropped)
//   rd_addr             NUM_RD packed read addresses, port k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data             NUM_RD packed read data, port k = [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy             port k's register has an outstanding reservation
//   rsv_valid/rsv_addr  reserve a register for a pending multi-cycle write
//   rsv_ready           rsv_addr is reservable
//   flush               clear all reservations (register data is kept)
//   rsv_err             sticky reservation-on-busy error, cleared by reset only
//   register_v0         contents of $v0
module mips_cpu_regfile_sb
    import mips_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int BYPASS     = 1,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         rsv_valid,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    output logic                         rsv_ready,
    input  logic                         flush,
    output logic                         rsv_err,
    output logic [DATA_WIDTH-1:0]        register_v0
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    // NOTE: the storage array is reset explicitly because the core relies on every
    // register reading zero after reset; a pure RAM macro could not offer this.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write && (wr_addr != ZERO_ADDR)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Any write retires the pending reservation on its register.
    mips_cpu_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .clr_valid (write),
        .clr_addr  (wr_addr),
        .flush     (flush),
        .busy      (busy),
        .rsv_ready (rsv_ready),
        .rsv_err   (rsv_err)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;

        assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        // The same-cycle write both forwards its data and hides the busy bit it is about to clear.
        assign hit  = (BYPASS != 0) && write && (wr_addr == addr) && (addr != ZERO_ADDR);

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = reset ? '0 :
                                                     hit   ? wr_data : regs[addr];
        assign rd_busy[k] = !reset && busy[addr] && !hit;
    end

    assign register_v0 = reset ? '0 : regs[REG_V0];

endmodule
